atsc_rsdec_multilane: RTL and testbench

//  Multi-lane scheduler for the ATSC Reed-Solomon decode stage in the RX RFNoC block. Splits the input stream

---
 rtl/atsc_rsdec_multilane.sv | 138 +++++++++++++
 tb/tb_atsc_rsdec_multilane.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atsc_rsdec_multilane.sv
// atsc_rsdec_multilane: round-robin dispatch of fixed-size segments to
// parallel RS decoder lanes, with in-order collection of decoded output.
module atsc_rsdec_multilane #(
    parameter int NUM_LANES    = 4,
    parameter int DATA_W       = 32,
    parameter int IN_SEG_WORDS = 52,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [NUM_LANES*DATA_W-1:0] lane_o_tdata,
    output logic [NUM_LANES-1:0]        lane_o_tlast,
    output logic [NUM_LANES-1:0]        lane_o_tvalid,
    input  logic [NUM_LANES-1:0]        lane_o_tready,
    input  logic [NUM_LANES*DATA_W-1:0] lane_i_tdata,
    input  logic [NUM_LANES-1:0]        lane_i_tlast,
    input  logic [NUM_LANES-1:0]        lane_i_tvalid,
    output logic [NUM_LANES-1:0]        lane_i_tready,
    input  logic [3:0]                  cfg_lanes,
    output logic [15:0]                 frame_err_cnt,
    output logic                        busy
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int WW = (IN_SEG_WORDS > 1) ? $clog2(IN_SEG_WORDS) : 1;
    localparam int FW = $clog2(MAX_INFLIGHT + 1);

    typedef logic [LW-1:0] ptr_t;
    typedef logic [FW-1:0] fl_t;

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    ptr_t          wr_nxt;
    ptr_t          rd_nxt;
    logic [WW-1:0] word_cnt;
    fl_t           in_flight [NUM_LANES];
    logic [3:0]    active_lanes;
    logic [3:0]    cfg_eff;
    logic          gate;
    logic          last_word;
    logic          seg_end;
    logic          s_fire;
    logic          m_fire;
    logic          inc;
    logic          dec;
    logic          reload;

    always_comb begin
        cfg_eff = cfg_lanes;
        if (cfg_lanes == 4'd0 || cfg_lanes > 4'(NUM_LANES))
            cfg_eff = 4'(NUM_LANES);

        last_word = (word_cnt == WW'(IN_SEG_WORDS - 1));
        seg_end   = last_word || s_axis_tlast;
        // Credit is only checked before the first word of a segment.
        gate = (word_cnt == '0) &&
               (in_flight[wr_ptr] == fl_t'(MAX_INFLIGHT));

        s_axis_tready = ap_rst_n && !gate && lane_o_tready[wr_ptr];
        s_fire        = s_axis_tvalid && s_axis_tready;

        m_axis_tdata  = lane_i_tdata[rd_ptr*DATA_W +: DATA_W];
        m_axis_tlast  = lane_i_tlast[rd_ptr];
        m_axis_tvalid = ap_rst_n && lane_i_tvalid[rd_ptr];
        m_fire        = m_axis_tvalid && m_axis_tready;

        inc = s_fire && seg_end;
        dec = m_fire && m_axis_tlast && (in_flight[rd_ptr] != '0);

        lane_o_tdata  = '0;
        lane_o_tlast  = '0;
        lane_o_tvalid = '0;
        lane_i_tready = '0;
        lane_o_tdata[wr_ptr*DATA_W +: DATA_W] = s_axis_tdata;
        lane_o_tlast[wr_ptr]  = seg_end;
        lane_o_tvalid[wr_ptr] = ap_rst_n && s_axis_tvalid && !gate;
        lane_i_tready[rd_ptr] = ap_rst_n && m_axis_tready;

        busy = (word_cnt != '0);
        for (int i = 0; i < NUM_LANES; i++)
            busy = busy | (in_flight[i] != '0);

        reload = !busy && !s_fire && (cfg_eff != active_lanes);

        wr_nxt = wr_ptr + ptr_t'(1);
        if (4'(wr_ptr) + 4'd1 >= active_lanes)
            wr_nxt = '0;
        rd_nxt = rd_ptr + ptr_t'(1);
        if (4'(rd_ptr) + 4'd1 >= active_lanes)
            rd_nxt = '0;
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_cnt      <= '0;
            frame_err_cnt <= '0;
            active_lanes  <= cfg_eff;
            for (int i = 0; i < NUM_LANES; i++)
                in_flight[i] <= '0;
        end else begin
            if (s_fire) begin
                word_cnt <= seg_end ? '0 : word_cnt + WW'(1);
                if ((s_axis_tlast != last_word) && (frame_err_cnt != 16'hFFFF))
                    frame_err_cnt <= frame_err_cnt + 16'd1;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                case ({inc && (wr_ptr == ptr_t'(i)),
                       dec && (rd_ptr == ptr_t'(i))})
                    2'b10:   in_flight[i] <= in_flight[i] + fl_t'(1);
                    2'b01:   in_flight[i] <= in_flight[i] - fl_t'(1);
                    default: in_flight[i] <= in_flight[i];
                endcase
            end
            // Lane count changes only with nothing in flight, so both
            // pointers can safely restart from lane 0.
            if (reload) begin
                active_lanes <= cfg_eff;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
            end else begin
                if (inc)
                    wr_ptr <= wr_nxt;
                if (dec)
                    rd_ptr <= rd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_atsc_rsdec_multilane.sv
// tb_atsc_rsdec_multilane: directed checks of ordering, credit gating,
// framing errors, lane reconfiguration and reset for atsc_rsdec_multilane.
`timescale 1ns/1ps
module tb_atsc_rsdec_multilane;
    localparam int NL  = 4;
    localparam int DW  = 32;
    localparam int SEG = 52;

    logic             ap_clk        = 1'b0;
    logic             ap_rst_n      = 1'b0;
    logic [DW-1:0]    s_axis_tdata  = '0;
    logic             s_axis_tlast  = 1'b0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic [NL*DW-1:0] lane_o_tdata;
    logic [NL-1:0]    lane_o_tlast;
    logic [NL-1:0]    lane_o_tvalid;
    logic [NL-1:0]    lane_o_tready;
    logic [NL*DW-1:0] lane_i_tdata;
    logic [NL-1:0]    lane_i_tlast;
    logic [NL-1:0]    lane_i_tvalid;
    logic [NL-1:0]    lane_i_tready;
    logic [3:0]       cfg_lanes     = 4'd0;
    logic [15:0]      frame_err_cnt;
    logic             busy;

    logic [NL-1:0] hold     = '0;
    logic          rand_rdy = 1'b0;
    logic [DW:0]   lmem [NL][256];
    logic [7:0]    hd [NL];
    logic [7:0]    tl [NL];
    int            segs [NL];
    logic [DW:0]   exp_w [16384];
    logic [DW:0]   got_w [16384];
    int            n_in     = 0;
    int            n_out    = 0;
    int            wpos     = 0;
    int            checks   = 0;
    int            failures = 0;

    always #5 ap_clk = ~ap_clk;

    assign lane_o_tready = '1;

    atsc_rsdec_multilane dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .lane_o_tdata  (lane_o_tdata),
        .lane_o_tlast  (lane_o_tlast),
        .lane_o_tvalid (lane_o_tvalid),
        .lane_o_tready (lane_o_tready),
        .lane_i_tdata  (lane_i_tdata),
        .lane_i_tlast  (lane_i_tlast),
        .lane_i_tvalid (lane_i_tvalid),
        .lane_i_tready (lane_i_tready),
        .cfg_lanes     (cfg_lanes),
        .frame_err_cnt (frame_err_cnt),
        .busy          (busy)
    );

    // Echoing decoder lanes: a FIFO per lane, output stalled by hold[].
    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign lane_i_tvalid[g] = (hd[g] != tl[g]) && !hold[g];
        assign lane_i_tdata[g*DW +: DW] = lmem[g][hd[g]][DW-1:0];
        assign lane_i_tlast[g] = lmem[g][hd[g]][DW];
    end

    always @(posedge ap_clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!ap_rst_n) begin
                hd[i] <= '0;
                tl[i] <= '0;
            end else begin
                if (lane_o_tvalid[i] && lane_o_tready[i]) begin
                    lmem[i][tl[i]] <= {lane_o_tlast[i], lane_o_tdata[i*DW +: DW]};
                    tl[i] <= tl[i] + 8'd1;
                    if (lane_o_tlast[i])
                        segs[i] <= segs[i] + 1;
                end
                if (lane_i_tvalid[i] && lane_i_tready[i])
                    hd[i] <= hd[i] + 8'd1;
            end
        end
    end

    always @(posedge ap_clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_w[n_out] <= {m_axis_tlast, m_axis_tdata};
            n_out <= n_out + 1;
        end
    end

    always @(negedge ap_clk)
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        int t;
        bit lt;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        t = 0;
        #1;
        while (!s_axis_tready && t < 2000) begin
            @(negedge ap_clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            chk("send_timeout", 32'(t), 32'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "FAIL input stalled");
        end
        @(posedge ap_clk);
        lt = (wpos == SEG - 1) || last;
        exp_w[n_in] = {lt, d};
        n_in++;
        wpos = lt ? 0 : wpos + 1;
        @(negedge ap_clk);
    endtask

    task automatic send_seg(input int id, input int n, input logic last_end);
        for (int k = 0; k < n; k++)
            send_word(32'((id << 16) | k), last_end && (k == n - 1));
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge ap_clk);
            t++;
        end
        chk(tag, 32'(t < 5000), 32'd1);
        repeat (3) @(negedge ap_clk);
    endtask

    task automatic check_stream(input string tag, input int ib, input int ob,
                                input int n);
        int bad;
        bad = 0;
        chk({tag, "_count"}, 32'(n_out - ob), 32'(n));
        for (int k = 0; k < n; k++)
            if (got_w[ob + k] !== exp_w[ib + k])
                bad++;
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int ib;
        int ob;
        int tlc;
        int s0 [NL];

        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst_s_tready_forced", 32'(s_axis_tready), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err_cnt), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_s_tready_idle", 32'(s_axis_tready), 32'd1);

        // Eight back-to-back full segments over four lanes.
        ib = n_in;
        ob = n_out;
        s0 = segs;
        for (int s = 0; s < 8; s++)
            send_seg(s, SEG, 1'b1);
        wait_idle("t1_drain");
        check_stream("t1", ib, ob, 8 * SEG);
        tlc = 0;
        for (int k = 0; k < 8 * SEG; k++)
            if (got_w[ob + k][DW] === 1'b1)
                tlc++;
        chk("t1_tlasts", 32'(tlc), 32'd8);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_frame_err", 32'(frame_err_cnt), 32'd0);
        chk("t1_lane3_segs", 32'(segs[3] - s0[3]), 32'd2);

        // Lane 0 output stalled: third lane-0 segment must be held back.
        hold = 4'b0001;
        ib = n_in;
        ob = n_out;
        for (int s = 0; s < 8; s++)
            send_seg(100 + s, SEG, 1'b1);
        s_axis_tdata  = 32'(108 << 16);
        s_axis_tvalid = 1'b1;
        repeat (4) @(negedge ap_clk);
        #1;
        chk("t2_gate", 32'(s_axis_tready), 32'd0);
        chk("t2_m_quiet", 32'(m_axis_tvalid), 32'd0);
        chk("t2_no_output", 32'(n_out - ob), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        hold = 4'b0000;
        send_seg(108, SEG, 1'b1);
        wait_idle("t2_drain");
        check_stream("t2", ib, ob, 9 * SEG);

        // Short segment, then a 60-word packet split at word 52.
        ib = n_in;
        ob = n_out;
        send_seg(200, 30, 1'b1);
        chk("t3_err_short", 32'(frame_err_cnt), 32'd1);
        for (int k = 0; k < 60; k++) begin
            send_word(32'((300 << 16) | k), k == 59);
            if (k == 51)
                chk("t3_err_long", 32'(frame_err_cnt), 32'd2);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_idle("t3_drain");
        check_stream("t3", ib, ob, 90);

        // Reset on word 20 of a segment.
        for (int k = 0; k < 20; k++)
            send_word(32'((400 << 16) | k), 1'b0);
        s_axis_tdata = 32'((400 << 16) | 20);
        ap_rst_n = 1'b0;
        #1;
        chk("t5_s_tready", 32'(s_axis_tready), 32'd0);
        chk("t5_lane_o_tvalid", 32'(lane_o_tvalid), 32'd0);
        chk("t5_lane_i_tready", 32'(lane_i_tready), 32'd0);
        chk("t5_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge ap_clk);
        s_axis_tvalid = 1'b0;
        ap_rst_n = 1'b1;
        wpos = 0;
        @(negedge ap_clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_frame_err", 32'(frame_err_cnt), 32'd0);
        chk("t5_m_idle", 32'(m_axis_tvalid), 32'd0);

        // First segment after reset lands on lane 0; cfg change waits.
        hold = '1;
        ib = n_in;
        ob = n_out;
        s0 = segs;
        send_seg(500, SEG, 1'b1);
        chk("t5_first_lane0", 32'(segs[0] - s0[0]), 32'd1);
        cfg_lanes = 4'd2;
        send_seg(501, SEG, 1'b1);
        send_seg(502, SEG, 1'b1);
        chk("t4_cfg_ignored_busy", 32'(segs[2] - s0[2]), 32'd1);
        hold = '0;
        wait_idle("t4_drain_a");
        s0 = segs;
        for (int s = 0; s < 4; s++)
            send_seg(510 + s, SEG, 1'b1);
        wait_idle("t4_drain_b");
        chk("t4_lane0_segs", 32'(segs[0] - s0[0]), 32'd2);
        chk("t4_lane1_segs", 32'(segs[1] - s0[1]), 32'd2);
        chk("t4_lane23_segs", 32'(segs[2] - s0[2] + segs[3] - s0[3]), 32'd0);
        check_stream("t4", ib, ob, 7 * SEG);

        // Long run with random output backpressure.
        cfg_lanes = 4'd0;
        repeat (3) @(negedge ap_clk);
        rand_rdy = 1'b1;
        ib = n_in;
        ob = n_out;
        for (int s = 0; s < 100; s++)
            send_seg(1000 + s, SEG, 1'b1);
        wait_idle("t6_drain");
        rand_rdy = 1'b0;
        check_stream("t6", ib, ob, 100 * SEG);
        chk("t6_frame_err", 32'(frame_err_cnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
